// File: rtl/alorium_lfsr_pkg.sv
// Shared encodings and reference tap masks for the programmable XNOR LFSR generator.
package alorium_lfsr_pkg;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FREE  = 2'd1,
    ST_BURST = 2'd2
  } lfsr_state_e;

  // Maximal-length XNOR tap masks (bit i set = state[i] feeds back)
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

endpackage

// File: rtl/alorium_lfsr_step.sv
// One Fibonacci XNOR LFSR step: feedback is the XNOR of the tapped state bits, shifted in at bit 0.
module alorium_lfsr_step
  import alorium_lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [WIDTH-1:0] next_o
);

  logic fb;

  assign fb     = ~^(state_i & taps_i);
  assign next_o = {state_i[WIDTH-2:0], fb};

endmodule

// File: rtl/alorium_lfsr_gen.sv
// Programmable-tap XNOR LFSR source with free-run / counted-burst modes and a valid/ready output.
// One value per clk under continuous ready; back-pressure stalls stepping and the burst count.
module alorium_lfsr_gen
  import alorium_lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(TAPS_W16),
  parameter int unsigned      CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_taps,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] taps
);

  localparam logic [WIDTH-1:0] STATE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  lfsr_state_e      fsm_q;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] taps_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] seed_guarded;
  logic [CNT_W-1:0] count_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             step_en;

  alorium_lfsr_step #(.WIDTH(WIDTH)) u_step (
    .state_i (state_q),
    .taps_i  (taps_q),
    .next_o  (state_d)
  );

  // All-ones is the XNOR lockup state, so it is never loaded
  assign seed_guarded = (seed == {WIDTH{1'b1}}) ? STATE_ONE : seed;
  assign step_en      = (fsm_q != ST_IDLE) && (!out_valid_q || out_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= ST_IDLE;
      state_q     <= STATE_ONE;
      taps_q      <= DEFAULT_TAPS;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (seed_we) begin
        state_q     <= seed_guarded;
        out_valid_q <= 1'b0;
        fsm_q       <= ST_IDLE;
        busy_q      <= 1'b0;
        count_q     <= '0;
      end else begin
        if (step_en) begin
          state_q     <= state_d;
          out_data_q  <= state_d;
          out_valid_q <= 1'b1;
        end else if (out_valid_q && out_ready) begin
          out_valid_q <= 1'b0;
        end

        if (cfg_we && (fsm_q == ST_IDLE)) begin
          taps_q <= cfg_taps;
        end

        case (fsm_q)
          ST_IDLE: begin
            if (start && (mode == MODE_FREE)) begin
              fsm_q  <= ST_FREE;
              busy_q <= 1'b1;
            end else if (start && (mode == MODE_BURST)) begin
              if (burst_len != '0) begin
                fsm_q   <= ST_BURST;
                busy_q  <= 1'b1;
                count_q <= burst_len;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          ST_FREE: begin
            if (mode != MODE_FREE) begin
              fsm_q  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
          ST_BURST: begin
            if (step_en) begin
              count_q <= count_q - CNT_W'(1);
              if (count_q == CNT_W'(1)) begin
                fsm_q  <= ST_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
          default: begin
            fsm_q  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign taps      = taps_q;

endmodule
